bp_io_cce_buffered: RTL and testbench



---
 rtl/bp_me_pkg.sv | 103 ++++++++++
 rtl/bp_io_cce_fifo.sv | 66 ++++++
 rtl/bp_io_cce_buffered.sv | 116 +++++++++++
 tb/tb_bp_io_cce_buffered.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bp_me_pkg.sv
// Shared message formats and uncached-message formatting helpers for I/O blocks.
package bp_me_pkg;

    localparam int unsigned cce_id_width_p    = 2;
    localparam int unsigned lce_id_width_p    = 2;
    localparam int unsigned paddr_width_p     = 40;
    localparam int unsigned cce_block_width_p = 64;

    typedef enum logic [2:0] {
        e_lce_req_type_rd = 3'd0,
        e_lce_req_type_wr = 3'd1,
        e_lce_req_uc_rd   = 3'd2,
        e_lce_req_uc_wr   = 3'd3
    } bp_lce_cce_req_type_e;

    typedef enum logic [3:0] {
        e_cce_mem_rd    = 4'd0,
        e_cce_mem_wr    = 4'd1,
        e_cce_mem_uc_rd = 4'd2,
        e_cce_mem_uc_wr = 4'd3
    } bp_cce_mem_cmd_type_e;

    typedef enum logic [3:0] {
        e_lce_cmd_sync        = 4'd0,
        e_lce_cmd_set_clear   = 4'd1,
        e_lce_cmd_transfer    = 4'd2,
        e_lce_cmd_writeback   = 4'd3,
        e_lce_cmd_set_tag     = 4'd4,
        e_lce_cmd_invalidate  = 4'd5,
        e_lce_cmd_uc_data     = 4'd6,
        e_lce_cmd_uc_st_done  = 4'd7
    } bp_lce_cmd_type_e;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        logic [lce_id_width_p-1:0]    src_id;
        bp_lce_cce_req_type_e         msg_type;
    } bp_lce_cce_req_s;

    typedef struct packed {
        logic [lce_id_width_p-1:0] lce_id;
        logic                      uncached;
    } bp_cce_mem_payload_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        bp_cce_mem_payload_s          payload;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        bp_cce_mem_cmd_type_e         msg_type;
    } bp_cce_mem_msg_s;

    typedef struct packed {
        logic [cce_block_width_p-1:0] data;
        logic [2:0]                   size;
        logic [paddr_width_p-1:0]     addr;
        logic [cce_id_width_p-1:0]    src_id;
        logic [lce_id_width_p-1:0]    dst_id;
        bp_lce_cmd_type_e             msg_type;
    } bp_lce_cmd_s;

    localparam int unsigned lce_cce_req_width_lp = $bits(bp_lce_cce_req_s);
    localparam int unsigned cce_mem_msg_width_lp = $bits(bp_cce_mem_msg_s);
    localparam int unsigned lce_cmd_width_lp     = $bits(bp_lce_cmd_s);

    function automatic logic is_uc_req(input bp_lce_cce_req_s req);
        return (req.msg_type == e_lce_req_uc_rd) || (req.msg_type == e_lce_req_uc_wr);
    endfunction

    // Uncached LCE request -> I/O memory command; read data is zeroed.
    function automatic bp_cce_mem_msg_s uc_req_to_io_cmd(input bp_lce_cce_req_s req);
        bp_cce_mem_msg_s cmd;
        cmd                  = '0;
        cmd.msg_type         = (req.msg_type == e_lce_req_uc_wr) ? e_cce_mem_uc_wr : e_cce_mem_uc_rd;
        cmd.addr             = req.addr;
        cmd.size             = req.size;
        cmd.payload.lce_id   = req.src_id;
        cmd.payload.uncached = 1'b1;
        cmd.data             = (req.msg_type == e_lce_req_uc_wr) ? req.data : '0;
        return cmd;
    endfunction

    // I/O memory response -> LCE command; store completions carry no size or data.
    function automatic bp_lce_cmd_s io_resp_to_lce_cmd(input bp_cce_mem_msg_s resp,
                                                       input logic [cce_id_width_p-1:0] cce_id);
        bp_lce_cmd_s cmd;
        cmd        = '0;
        cmd.dst_id = resp.payload.lce_id;
        cmd.src_id = cce_id;
        cmd.addr   = resp.addr;
        if (resp.msg_type == e_cce_mem_uc_wr) begin
            cmd.msg_type = e_lce_cmd_uc_st_done;
        end else begin
            cmd.msg_type = e_lce_cmd_uc_data;
            cmd.size     = resp.size;
            cmd.data     = resp.data;
        end
        return cmd;
    endfunction

endpackage

// File: rtl/bp_io_cce_fifo.sv
// Circular-buffer FIFO: ready/valid enqueue, valid/yumi dequeue, occupancy-counted.
module bp_io_cce_fifo #(
    parameter int unsigned width_p = 8,
    parameter int unsigned els_p   = 2
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    input  logic               v_i,
    output logic               ready_o,
    output logic [width_p-1:0] data_o,
    output logic               v_o,
    input  logic               yumi_i
);

    localparam int unsigned ptr_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
    localparam int unsigned cnt_w_lp = $clog2(els_p + 1);

    logic [width_p-1:0]  mem_q [els_p];
    logic [ptr_w_lp-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                enq, deq;

    function automatic logic [ptr_w_lp-1:0] next_ptr(input logic [ptr_w_lp-1:0] p);
        return (p == ptr_w_lp'(els_p - 1)) ? '0 : p + ptr_w_lp'(1);
    endfunction

    assign ready_o = (cnt_q != cnt_w_lp'(els_p));
    assign v_o     = (cnt_q != '0);
    assign data_o  = mem_q[rd_ptr_q];
    assign enq     = v_i & ready_o;
    assign deq     = yumi_i & v_o;

    // Next pointers and occupancy from this cycle's enqueue/dequeue.
    always_comb begin
        rd_ptr_d = deq ? next_ptr(rd_ptr_q) : rd_ptr_q;
        wr_ptr_d = enq ? next_ptr(wr_ptr_q) : wr_ptr_q;
        cnt_d    = cnt_q;
        if (enq && !deq) begin
            cnt_d = cnt_q + cnt_w_lp'(1);
        end else if (deq && !enq) begin
            cnt_d = cnt_q - cnt_w_lp'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage write; contents are don't-care until counted as occupied.
    always_ff @(posedge clk_i) begin
        if (enq) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/bp_io_cce_buffered.sv
// Buffered uncached I/O CCE: LCE requests -> I/O commands, I/O responses -> LCE commands.
module bp_io_cce_buffered
    import bp_me_pkg::*;
#(
    parameter int unsigned buffer_els_p      = 2,
    parameter int unsigned outstanding_els_p = 4
) (
    input  logic                            clk_i,
    input  logic                            reset_n_i,
    input  logic [cce_id_width_p-1:0]       cce_id_i,

    input  logic [lce_cce_req_width_lp-1:0] lce_req_i,
    input  logic                            lce_req_v_i,
    output logic                            lce_req_yumi_o,

    output logic [lce_cmd_width_lp-1:0]     lce_cmd_o,
    output logic                            lce_cmd_v_o,
    input  logic                            lce_cmd_ready_i,

    output logic [cce_mem_msg_width_lp-1:0] io_cmd_o,
    output logic                            io_cmd_v_o,
    input  logic                            io_cmd_ready_i,

    input  logic [cce_mem_msg_width_lp-1:0] io_resp_i,
    input  logic                            io_resp_v_i,
    output logic                            io_resp_yumi_o,

    output logic                            idle_o,
    output logic                            error_o
);

    localparam int unsigned cnt_w_lp = $clog2(outstanding_els_p + 1);

    bp_lce_cce_req_s     lce_req_li;
    bp_cce_mem_msg_s     io_resp_li;
    bp_cce_mem_msg_s     io_cmd_fmt;
    bp_lce_cmd_s         lce_cmd_fmt;
    logic                req_ready, req_v, req_enq;
    logic                resp_ready, resp_v;
    logic                io_cmd_hs, lce_cmd_hs;
    logic [cnt_w_lp-1:0] cnt_q, cnt_d;
    logic                error_q, error_d;

    assign lce_req_li  = lce_req_i;
    assign io_resp_li  = io_resp_i;
    assign io_cmd_fmt  = uc_req_to_io_cmd(lce_req_li);
    assign lce_cmd_fmt = io_resp_to_lce_cmd(io_resp_li, cce_id_i);

    // Yumis are gated by reset so nothing is consumed while reset is held.
    assign lce_req_yumi_o = lce_req_v_i & req_ready & reset_n_i;
    assign io_resp_yumi_o = io_resp_v_i & resp_ready & reset_n_i;
    assign req_enq        = lce_req_yumi_o & is_uc_req(lce_req_li);

    assign io_cmd_v_o  = req_v & (cnt_q < cnt_w_lp'(outstanding_els_p));
    assign lce_cmd_v_o = resp_v;
    assign io_cmd_hs   = io_cmd_v_o & io_cmd_ready_i;
    assign lce_cmd_hs  = lce_cmd_v_o & lce_cmd_ready_i;

    assign idle_o  = (cnt_q == '0) & ~req_v & ~resp_v;
    assign error_o = error_q;

    bp_io_cce_fifo #(
        .width_p(cce_mem_msg_width_lp),
        .els_p  (buffer_els_p)
    ) req_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .data_i   (io_cmd_fmt),
        .v_i      (req_enq),
        .ready_o  (req_ready),
        .data_o   (io_cmd_o),
        .v_o      (req_v),
        .yumi_i   (io_cmd_hs)
    );

    bp_io_cce_fifo #(
        .width_p(lce_cmd_width_lp),
        .els_p  (buffer_els_p)
    ) resp_fifo (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .data_i   (lce_cmd_fmt),
        .v_i      (io_resp_yumi_o),
        .ready_o  (resp_ready),
        .data_o   (lce_cmd_o),
        .v_o      (resp_v),
        .yumi_i   (lce_cmd_hs)
    );

    // Outstanding count; decrement saturates so stray post-reset responses are harmless.
    always_comb begin
        cnt_d = cnt_q;
        if (io_cmd_hs && !lce_cmd_hs) begin
            cnt_d = cnt_q + cnt_w_lp'(1);
        end else if (lce_cmd_hs && !io_cmd_hs && (cnt_q != '0)) begin
            cnt_d = cnt_q - cnt_w_lp'(1);
        end
    end

    // Sticky error on any consumed non-uncached request.
    always_comb begin
        error_d = error_q | (lce_req_yumi_o & ~is_uc_req(lce_req_li));
    end

    // State registers for the counter and error flag.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            cnt_q   <= '0;
            error_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            error_q <= error_d;
        end
    end

endmodule

// File: tb/tb_bp_io_cce_buffered.sv
// Directed self-checking bench for bp_io_cce_buffered.
module tb_bp_io_cce_buffered;
    import bp_me_pkg::*;

    logic                            clk = 1'b0;
    logic                            reset_n_i;
    logic [cce_id_width_p-1:0]       cce_id_i;
    logic [lce_cce_req_width_lp-1:0] lce_req_i;
    logic                            lce_req_v_i, lce_req_yumi_o;
    logic [lce_cmd_width_lp-1:0]     lce_cmd_o;
    logic                            lce_cmd_v_o, lce_cmd_ready_i;
    logic [cce_mem_msg_width_lp-1:0] io_cmd_o;
    logic                            io_cmd_v_o, io_cmd_ready_i;
    logic [cce_mem_msg_width_lp-1:0] io_resp_i;
    logic                            io_resp_v_i, io_resp_yumi_o;
    logic                            idle_o, error_o;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    bp_io_cce_buffered #(
        .buffer_els_p     (2),
        .outstanding_els_p(4)
    ) dut (
        .clk_i          (clk),
        .reset_n_i      (reset_n_i),
        .cce_id_i       (cce_id_i),
        .lce_req_i      (lce_req_i),
        .lce_req_v_i    (lce_req_v_i),
        .lce_req_yumi_o (lce_req_yumi_o),
        .lce_cmd_o      (lce_cmd_o),
        .lce_cmd_v_o    (lce_cmd_v_o),
        .lce_cmd_ready_i(lce_cmd_ready_i),
        .io_cmd_o       (io_cmd_o),
        .io_cmd_v_o     (io_cmd_v_o),
        .io_cmd_ready_i (io_cmd_ready_i),
        .io_resp_i      (io_resp_i),
        .io_resp_v_i    (io_resp_v_i),
        .io_resp_yumi_o (io_resp_yumi_o),
        .idle_o         (idle_o),
        .error_o        (error_o)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bp_lce_cce_req_s mk_req(input bp_lce_cce_req_type_e t, input logic [1:0] src,
                                               input logic [39:0] a, input logic [2:0] sz,
                                               input logic [63:0] d);
        bp_lce_cce_req_s r;
        r.msg_type = t; r.src_id = src; r.addr = a; r.size = sz; r.data = d;
        return r;
    endfunction

    function automatic bp_cce_mem_msg_s mk_mem(input bp_cce_mem_cmd_type_e t, input logic [39:0] a,
                                               input logic [2:0] sz, input logic [1:0] lce,
                                               input logic unc, input logic [63:0] d);
        bp_cce_mem_msg_s m;
        m.msg_type = t; m.addr = a; m.size = sz;
        m.payload.lce_id = lce; m.payload.uncached = unc; m.data = d;
        return m;
    endfunction

    function automatic bp_lce_cmd_s mk_cmd(input bp_lce_cmd_type_e t, input logic [1:0] dst,
                                           input logic [1:0] src, input logic [39:0] a,
                                           input logic [2:0] sz, input logic [63:0] d);
        bp_lce_cmd_s c;
        c.msg_type = t; c.dst_id = dst; c.src_id = src; c.addr = a; c.size = sz; c.data = d;
        return c;
    endfunction

    task automatic idle_inputs();
        lce_req_v_i     = 1'b0;
        io_resp_v_i     = 1'b0;
        io_cmd_ready_i  = 1'b0;
        lce_cmd_ready_i = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n_i = 1'b0;
        idle_inputs();
        @(negedge clk);
        reset_n_i = 1'b1;
    endtask

    initial begin
        int unsigned sent;
        int unsigned issued;

        reset_n_i = 1'b0;
        cce_id_i  = 2'd2;
        idle_inputs();
        lce_req_i   = mk_req(e_lce_req_uc_rd, 2'd0, 40'h0, 3'd0, 64'h0);
        io_resp_i   = mk_mem(e_cce_mem_uc_rd, 40'h0, 3'd0, 2'd0, 1'b1, 64'h0);
        lce_req_v_i = 1'b1;
        io_resp_v_i = 1'b1;
        #2;
        check("rst_req_yumi", 128'(lce_req_yumi_o), 128'(0));
        check("rst_resp_yumi", 128'(io_resp_yumi_o), 128'(0));
        check("rst_io_cmd_v", 128'(io_cmd_v_o), 128'(0));
        check("rst_lce_cmd_v", 128'(lce_cmd_v_o), 128'(0));
        check("rst_idle", 128'(idle_o), 128'(1));
        check("rst_error", 128'(error_o), 128'(0));
        do_reset();

        // Single uncached read and its data response.
        @(negedge clk);
        lce_req_v_i = 1'b1;
        lce_req_i   = mk_req(e_lce_req_uc_rd, 2'd1, 40'h80_0000_40, 3'd3, 64'hFFFF);
        #1;
        check("rd_yumi", 128'(lce_req_yumi_o), 128'(1));
        check("rd_latency", 128'(io_cmd_v_o), 128'(0));
        @(negedge clk);
        lce_req_v_i    = 1'b0;
        io_cmd_ready_i = 1'b1;
        #1;
        check("rd_io_cmd_v", 128'(io_cmd_v_o), 128'(1));
        check("rd_io_cmd", 128'(io_cmd_o),
              128'(mk_mem(e_cce_mem_uc_rd, 40'h80_0000_40, 3'd3, 2'd1, 1'b1, 64'h0)));
        @(negedge clk);
        io_cmd_ready_i = 1'b0;
        io_resp_v_i    = 1'b1;
        io_resp_i      = mk_mem(e_cce_mem_uc_rd, 40'h80_0000_40, 3'd3, 2'd1, 1'b1, 64'hDEAD_BEEF);
        #1;
        check("rd_busy", 128'(idle_o), 128'(0));
        check("rd_resp_yumi", 128'(io_resp_yumi_o), 128'(1));
        check("rd_resp_latency", 128'(lce_cmd_v_o), 128'(0));
        @(negedge clk);
        io_resp_v_i     = 1'b0;
        lce_cmd_ready_i = 1'b1;
        #1;
        check("rd_lce_cmd_v", 128'(lce_cmd_v_o), 128'(1));
        check("rd_lce_cmd", 128'(lce_cmd_o),
              128'(mk_cmd(e_lce_cmd_uc_data, 2'd1, 2'd2, 40'h80_0000_40, 3'd3, 64'hDEAD_BEEF)));
        @(negedge clk);
        lce_cmd_ready_i = 1'b0;
        #1;
        check("rd_idle", 128'(idle_o), 128'(1));

        // Uncached write and its store completion.
        @(negedge clk);
        lce_req_v_i = 1'b1;
        lce_req_i   = mk_req(e_lce_req_uc_wr, 2'd3, 40'h10, 3'd2, 64'h1234);
        @(negedge clk);
        lce_req_v_i    = 1'b0;
        io_cmd_ready_i = 1'b1;
        #1;
        check("wr_io_cmd", 128'(io_cmd_o),
              128'(mk_mem(e_cce_mem_uc_wr, 40'h10, 3'd2, 2'd3, 1'b1, 64'h1234)));
        @(negedge clk);
        io_cmd_ready_i = 1'b0;
        io_resp_v_i    = 1'b1;
        io_resp_i      = mk_mem(e_cce_mem_uc_wr, 40'h10, 3'd2, 2'd3, 1'b1, 64'hCAFE);
        @(negedge clk);
        io_resp_v_i     = 1'b0;
        lce_cmd_ready_i = 1'b1;
        #1;
        check("wr_lce_cmd", 128'(lce_cmd_o),
              128'(mk_cmd(e_lce_cmd_uc_st_done, 2'd3, 2'd2, 40'h10, 3'd0, 64'h0)));
        @(negedge clk);
        lce_cmd_ready_i = 1'b0;

        // Six reads against a limit of four.
        sent   = 0;
        issued = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            io_cmd_ready_i = 1'b1;
            lce_req_v_i    = (sent < 6);
            lce_req_i      = mk_req(e_lce_req_uc_rd, 2'd0, 40'h100 + 40'(sent * 8), 3'd3, 64'h0);
            #1;
            if (lce_req_yumi_o) sent++;
            if (io_cmd_v_o) issued++;
        end
        @(negedge clk);
        lce_req_v_i = 1'b0;
        #1;
        check("lim_sent", 128'(sent), 128'(6));
        check("lim_issued", 128'(issued), 128'(4));
        check("lim_v_low", 128'(io_cmd_v_o), 128'(0));
        check("lim_idle", 128'(idle_o), 128'(0));
        @(negedge clk);
        io_resp_v_i = 1'b1;
        io_resp_i   = mk_mem(e_cce_mem_uc_rd, 40'h100, 3'd3, 2'd0, 1'b1, 64'h55);
        #1;
        check("lim_resp_yumi", 128'(io_resp_yumi_o), 128'(1));
        @(negedge clk);
        io_resp_v_i     = 1'b0;
        lce_cmd_ready_i = 1'b1;
        #1;
        check("lim_lce_cmd_v", 128'(lce_cmd_v_o), 128'(1));
        check("lim_hold_same_cycle", 128'(io_cmd_v_o), 128'(0));
        @(negedge clk);
        lce_cmd_ready_i = 1'b0;
        #1;
        check("lim_next_issue", 128'(io_cmd_v_o), 128'(1));
        check("lim_fifth_addr", 128'(io_cmd_o),
              128'(mk_mem(e_cce_mem_uc_rd, 40'h120, 3'd3, 2'd0, 1'b1, 64'h0)));
        do_reset();

        // Backpressure in both directions, then drain in order.
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lce_req_v_i = 1'b1;
            lce_req_i   = mk_req(e_lce_req_uc_rd, 2'd1, 40'h200 + 40'(k * 64), 3'd3, 64'h0);
            io_resp_v_i = 1'b1;
            io_resp_i   = mk_mem(e_cce_mem_uc_rd, 40'h300, 3'd3, 2'd2, 1'b1, 64'hA0 + 64'(k));
            #1;
            check("bp_req_yumi", 128'(lce_req_yumi_o), 128'(k < 2));
            check("bp_resp_yumi", 128'(io_resp_yumi_o), 128'(k < 2));
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            lce_req_v_i     = 1'b0;
            io_resp_v_i     = 1'b0;
            io_cmd_ready_i  = 1'b1;
            lce_cmd_ready_i = 1'b1;
            #1;
            check("bp_io_order", 128'(io_cmd_o),
                  128'(mk_mem(e_cce_mem_uc_rd, 40'h200 + 40'(k * 64), 3'd3, 2'd1, 1'b1, 64'h0)));
            check("bp_lce_order", 128'(lce_cmd_o),
                  128'(mk_cmd(e_lce_cmd_uc_data, 2'd2, 2'd2, 40'h300, 3'd3, 64'hA0 + 64'(k))));
        end
        @(negedge clk);
        io_cmd_ready_i  = 1'b0;
        lce_cmd_ready_i = 1'b0;
        #1;
        check("bp_drained_io", 128'(io_cmd_v_o), 128'(0));
        check("bp_drained_lce", 128'(lce_cmd_v_o), 128'(0));
        check("bp_same_cycle_cnt_idle", 128'(idle_o), 128'(1));

        // Cached request is consumed and flags a sticky error.
        @(negedge clk);
        lce_req_v_i = 1'b1;
        lce_req_i   = mk_req(e_lce_req_type_rd, 2'd1, 40'h500, 3'd3, 64'h0);
        #1;
        check("err_yumi", 128'(lce_req_yumi_o), 128'(1));
        check("err_before", 128'(error_o), 128'(0));
        @(negedge clk);
        lce_req_v_i = 1'b0;
        #1;
        check("err_set", 128'(error_o), 128'(1));
        check("err_no_io_cmd", 128'(io_cmd_v_o), 128'(0));
        check("err_idle", 128'(idle_o), 128'(1));
        repeat (3) @(negedge clk);
        #1;
        check("err_sticky", 128'(error_o), 128'(1));
        do_reset();
        #1;
        check("err_cleared", 128'(error_o), 128'(0));

        // Reset with three outstanding and queued traffic in both directions.
        sent   = 0;
        issued = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            io_cmd_ready_i = (issued < 3);
            lce_req_v_i    = (sent < 4);
            lce_req_i      = mk_req(e_lce_req_uc_rd, 2'd0, 40'h600 + 40'(sent * 8), 3'd3, 64'h0);
            #1;
            if (lce_req_yumi_o) sent++;
            if (io_cmd_v_o && io_cmd_ready_i) issued++;
        end
        @(negedge clk);
        lce_req_v_i    = 1'b0;
        io_cmd_ready_i = 1'b0;
        io_resp_v_i    = 1'b1;
        io_resp_i      = mk_mem(e_cce_mem_uc_rd, 40'h600, 3'd3, 2'd0, 1'b1, 64'h77);
        @(negedge clk);
        io_resp_v_i = 1'b0;
        #1;
        check("rst3_issued", 128'(issued), 128'(3));
        check("rst3_pending_io", 128'(io_cmd_v_o), 128'(1));
        check("rst3_pending_lce", 128'(lce_cmd_v_o), 128'(1));
        @(negedge clk);
        reset_n_i   = 1'b0;
        lce_req_v_i = 1'b1;
        io_resp_v_i = 1'b1;
        #1;
        check("rst3_req_yumi", 128'(lce_req_yumi_o), 128'(0));
        check("rst3_resp_yumi", 128'(io_resp_yumi_o), 128'(0));
        check("rst3_io_v", 128'(io_cmd_v_o), 128'(0));
        check("rst3_lce_v", 128'(lce_cmd_v_o), 128'(0));
        check("rst3_idle", 128'(idle_o), 128'(1));
        @(negedge clk);
        reset_n_i   = 1'b1;
        lce_req_v_i = 1'b0;
        io_resp_i   = mk_mem(e_cce_mem_uc_wr, 40'h400, 3'd2, 2'd3, 1'b1, 64'h99);
        #1;
        check("stray_resp_yumi", 128'(io_resp_yumi_o), 128'(1));
        @(negedge clk);
        io_resp_v_i     = 1'b0;
        lce_cmd_ready_i = 1'b1;
        #1;
        check("stray_lce_cmd", 128'(lce_cmd_o),
              128'(mk_cmd(e_lce_cmd_uc_st_done, 2'd3, 2'd2, 40'h400, 3'd0, 64'h0)));
        @(negedge clk);
        lce_cmd_ready_i = 1'b0;
        #1;
        check("stray_no_underflow", 128'(idle_o), 128'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
